attopu_prog_loader: RTL

// Upstream boot stage for the attopu processor: receives a byte stream and packs bytes into
// 16-bit instruction words. Writes the words into the instruction memory the processor fetches from.

---
 rtl/attopu_prog_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/attopu_prog_loader.sv
// attopu program loader: receives a length-prefixed byte stream, packs byte pairs
// into 16-bit instruction words and writes them to instruction memory. It keeps
// the processor in reset while loading and releases it only after the length and
// XOR checksum are good.
module attopu_prog_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter bit BOOT_RUN   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [31:0]           DEPTH32  = 32'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_len_lo;
  logic [7:0]  r_lo;
  logic [7:0]  r_cks;
  logic [15:0] r_len;
  logic [15:0] r_wcnt;

  logic        w_xfer;
  logic        w_start_ok;
  logic [15:0] w_len;
  logic        w_too_long;
  logic        w_last;

  assign w_xfer     = byte_valid & byte_ready;
  assign w_start_ok = start & ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_len      = {byte_data, r_len_lo};
  assign w_too_long = {16'd0, w_len} > DEPTH32;
  assign w_last     = (r_wcnt == (r_len - 16'd1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; byte_ready is high in every stream-consuming state.
  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (w_xfer) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (w_xfer) begin
          if (w_too_long)          w_next = S_ERR;
          else if (w_len == 16'd0) w_next = S_CHECK;
          else                     w_next = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        byte_ready = 1'b1;
        if (w_xfer) w_next = S_DATA_HI;
      end
      S_DATA_HI: begin
        byte_ready = 1'b1;
        if (w_xfer) w_next = w_last ? S_CHECK : S_DATA_LO;
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        if (w_xfer) w_next = ((r_cks ^ byte_data) == 8'h00) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath, write strobe and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 16'd0;
      cpu_rst   <= ~BOOT_RUN;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      r_len_lo  <= 8'd0;
      r_lo      <= 8'd0;
      r_cks     <= 8'd0;
      r_len     <= 16'd0;
      r_wcnt    <= 16'd0;
    end else begin
      mem_we <= 1'b0;
      // Address advances the cycle after each strobe; wraps naturally when N == DEPTH.
      if (mem_we) mem_addr <= mem_addr + ADDR_ONE;

      if (w_start_ok) begin
        cpu_rst  <= 1'b1;
        busy     <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
        mem_addr <= '0;
        r_cks    <= 8'd0;
        r_wcnt   <= 16'd0;
      end

      if (w_xfer) begin
        r_cks <= r_cks ^ byte_data;
        case (r_state)
          S_LEN_LO:  r_len_lo <= byte_data;
          S_LEN_HI:  r_len    <= w_len;
          S_DATA_LO: r_lo     <= byte_data;
          S_DATA_HI: begin
            mem_we    <= 1'b1;
            mem_wdata <= {byte_data, r_lo};
            r_wcnt    <= r_wcnt + 16'd1;
          end
          default: ;
        endcase
      end

      // Successful load releases the processor; a failed one keeps it held.
      if ((r_state != S_DONE) && (w_next == S_DONE)) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        cpu_rst <= 1'b0;
      end
      if ((r_state != S_ERR) && (w_next == S_ERR)) begin
        busy <= 1'b0;
        err  <= 1'b1;
      end
    end
  end

endmodule
